// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Brief    : Time-multiplexed seven-segment scanner with blanking gap and a
//            registered manual-select mode. Optional duty dimming is enabled
//            by defining SEG_SCAN_MUX_DIM_EN (adds the i_duty port).
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_mux #(
    parameter int NUM_CH = 4,
    parameter int SEG_W  = 7,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 16,
    parameter int SEL_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [NUM_CH*SEG_W-1:0] i_seg_flat,
    input  logic                    i_manual,
    input  logic [SEL_W-1:0]        i_sel,
`ifdef SEG_SCAN_MUX_DIM_EN
    input  logic [3:0]              i_duty,
`endif
    output logic [SEG_W-1:0]        o_seg,
    output logic [NUM_CH-1:0]       o_dig,
    output logic [SEL_W-1:0]        o_sel,
    output logic                    o_frame
);

    localparam int               CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] C_BLANK    = CNT_W'(BLANK);
    localparam logic [SEL_W-1:0] C_SEL_LAST = SEL_W'(NUM_CH - 1);

    logic [CNT_W-1:0]  r_cnt_q,   w_cnt_d;
    logic [SEL_W-1:0]  r_sel_q,   w_sel_d;
    logic              r_pend_q,  w_pend_d;
    logic [SEG_W-1:0]  r_seg_q,   w_seg_d;
    logic [NUM_CH-1:0] r_dig_q,   w_dig_d;
    logic [SEL_W-1:0]  r_osel_q,  w_osel_d;
    logic              r_frame_q, w_frame_d;

    logic              w_sel_ok;
    logic [SEL_W-1:0]  w_idx;
    logic [SEG_W-1:0]  w_slice;
    logic [NUM_CH-1:0] w_onehot;
    logic              w_lit;

    assign w_sel_ok = (int'(i_sel) < NUM_CH);
    assign w_idx    = i_manual ? i_sel : r_sel_q;
    assign w_slice  = i_seg_flat[int'(w_idx)*SEG_W +: SEG_W];
    assign w_onehot = NUM_CH'(1) << w_idx;

`ifdef SEG_SCAN_MUX_DIM_EN
    logic [3:0] r_dim_q, w_dim_d;
    logic [3:0] w_phase;

    // Only consulted during SHOW, where cnt >= BLANK, so the difference never wraps.
    assign w_dim_d = r_dim_q + 4'd1;
    assign w_phase = i_manual ? r_dim_q : 4'(r_cnt_q - C_BLANK);
    assign w_lit   = (w_phase < i_duty);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dim_q <= '0;
        end else begin
            r_dim_q <= w_dim_d;
        end
    end
`else
    assign w_lit = 1'b1;
`endif

    always_comb begin
        w_cnt_d   = r_cnt_q;
        w_sel_d   = r_sel_q;
        w_pend_d  = r_pend_q;
        w_seg_d   = '0;
        w_dig_d   = '0;
        w_osel_d  = r_sel_q;
        w_frame_d = 1'b0;

        if (i_manual) begin
            // Out-of-range selects park on channel 0 so the auto restart is sane.
            w_cnt_d  = '0;
            w_pend_d = 1'b0;
            w_sel_d  = w_sel_ok ? i_sel : '0;
            w_osel_d = w_sel_d;
            if (i_en && w_sel_ok) begin
                w_seg_d = w_slice;
                w_dig_d = w_lit ? w_onehot : '0;
            end
        end else if (i_en) begin
            if (r_cnt_q >= C_BLANK) begin
                w_seg_d = w_slice;
                w_dig_d = w_lit ? w_onehot : '0;
            end
            if ((r_cnt_q == '0) && (r_sel_q == '0) && r_pend_q) begin
                w_frame_d = 1'b1;
                w_pend_d  = 1'b0;
            end
            if (r_cnt_q == C_CNT_LAST) begin
                w_cnt_d = '0;
                if (r_sel_q == C_SEL_LAST) begin
                    w_sel_d  = '0;
                    w_pend_d = 1'b1;
                end else begin
                    w_sel_d = r_sel_q + 1'b1;
                end
            end else begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt_q   <= '0;
            r_sel_q   <= '0;
            r_pend_q  <= 1'b0;
            r_seg_q   <= '0;
            r_dig_q   <= '0;
            r_osel_q  <= '0;
            r_frame_q <= 1'b0;
        end else begin
            r_cnt_q   <= w_cnt_d;
            r_sel_q   <= w_sel_d;
            r_pend_q  <= w_pend_d;
            r_seg_q   <= w_seg_d;
            r_dig_q   <= w_dig_d;
            r_osel_q  <= w_osel_d;
            r_frame_q <= w_frame_d;
        end
    end

    assign o_seg   = r_seg_q;
    assign o_dig   = r_dig_q;
    assign o_sel   = r_osel_q;
    assign o_frame = r_frame_q;

endmodule
`default_nettype wire
